// File: rtl/norm_shift_detect_pkg.sv
// Shared types and helpers for the normalize-shift detector.
// Holds the FSM state type, direction codes and the stage zero test.
package norm_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    // Widest word the zero test handles; callers zero-extend into it.
    localparam int NMAX = 256;

    // True when bits [n-1 : n-2^k] of w are all zero.
    function automatic logic top_zero(
        input logic [NMAX-1:0] w,
        input int              n,
        input int              k
    );
        logic z;
        z = 1'b1;
        for (int i = 0; i < NMAX; i++) begin
            if (i < n && i >= n - (1 << k) && w[i]) begin
                z = 1'b0;
            end
        end
        return z;
    endfunction

endpackage

// File: rtl/norm_shift_detect_if.sv
// Input/output valid-ready bundle for norm_shift_detect.
// master drives words in and accepts results; slave is the detector.
interface norm_shift_detect_if #(
    parameter int N = 8
);
    localparam int W = $clog2(N);

    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_data;
    logic         in_dir;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_data;
    logic [W-1:0] out_shift;
    logic         out_zero;

    modport master (
        output in_valid,
        output in_data,
        output in_dir,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_shift,
        input  out_zero
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_dir,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_shift,
        output out_zero
    );

endinterface

// File: rtl/norm_shift_detect_bit_reverse.sv
// Combinational bit reversal: dout[i] = din[N-1-i].
// Lets one left-normalizing datapath also serve right normalization.
module bit_reverse #(
    parameter int N = 8
) (
    input  logic [N-1:0] din,
    output logic [N-1:0] dout
);

    for (genvar i = 0; i < N; i++) begin : g_rev
        assign dout[i] = din[N-1-i];
    end

endmodule

// File: rtl/norm_shift_detect.sv
// Iterative leading/trailing-zero normalizer, one binary-search stage per clock.
// Define NORM_BACK2BACK_EN to accept a new word on the same edge a result leaves.
import norm_pkg::*;

module norm_shift_detect #(
    parameter  int N = 8,
    localparam int W = $clog2(N)
) (
    input  logic                clk,
    input  logic                rst,
    norm_shift_detect_if.slave  io
);

    state_t       state_q, state_d;
    logic [N-1:0] work_q, work_d;
    logic         dir_q, dir_d;
    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] shift_q, shift_d;
    logic         zero_q, zero_d;

    logic [N-1:0] in_rev;
    logic [N-1:0] work_rev;
    logic [N-1:0] load_word;
    logic         in_ready;
    logic         accept;
    logic         stage_zero;

    bit_reverse #(.N(N)) u_in_rev (
        .din  (io.in_data),
        .dout (in_rev)
    );

    bit_reverse #(.N(N)) u_out_rev (
        .din  (work_q),
        .dout (work_rev)
    );

    // Right normalize runs as a left normalize on the mirrored word.
    assign load_word = (io.in_dir == DIR_RIGHT) ? in_rev : io.in_data;

    always_comb begin
        in_ready = (state_q == IDLE);
`ifdef NORM_BACK2BACK_EN
        if (state_q == DONE) begin
            in_ready = io.out_ready;
        end
`endif
    end

    assign accept     = io.in_valid & in_ready;
    assign stage_zero = top_zero(NMAX'(work_q), N, int'(cnt_q));

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        dir_d   = dir_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        zero_d  = zero_q;

        unique case (state_q)
            IDLE: begin
                state_d = IDLE;
            end
            SHIFT: begin
                if (stage_zero) begin
                    work_d         = work_q << (1 << cnt_q);
                    shift_d[cnt_q] = 1'b1;
                end
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                if (io.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A new word may arrive from IDLE or, back-to-back, from DONE.
        if (accept) begin
            state_d = SHIFT;
            work_d  = load_word;
            dir_d   = io.in_dir;
            cnt_d   = W'(W - 1);
            shift_d = '0;
            zero_d  = (io.in_data == '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            work_q  <= '0;
            dir_q   <= DIR_LEFT;
            cnt_q   <= '0;
            shift_q <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            dir_q   <= dir_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            zero_q  <= zero_d;
        end
    end

    assign io.in_ready  = in_ready;
    assign io.out_valid = (state_q == DONE);
    assign io.out_shift = shift_q;
    assign io.out_zero  = zero_q;

    always_comb begin
        io.out_data = '0;
        if (state_q == DONE) begin
            io.out_data = (dir_q == DIR_LEFT) ? work_q : work_rev;
        end
    end

endmodule

// File: tb/tb_norm_shift_detect.sv
// Self-checking bench for norm_shift_detect (N=8): directed vectors plus
// a count-the-zeros reference model checked on every valid output cycle.
module tb_norm_shift_detect;

    localparam int N = 8;
    localparam int W = 3;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    norm_shift_detect_if #(.N(N)) io ();

    norm_shift_detect #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .io  (io)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [N-1:0] d;
        logic [W-1:0] s;
        logic         z;
        int           acc;
        bit           seen;
    } exp_t;

    typedef struct {
        logic [N-1:0] d;
        logic [W-1:0] s;
        logic         z;
        int           cyc;
    } res_t;

    exp_t exp_q[$];
    res_t res_q[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, want, $time);
        end
    endtask

    // Count zeros from the relevant end, then shift them out.
    function automatic exp_t model(input logic [N-1:0] d, input logic dir);
        exp_t e;
        int   c;
        e.acc  = 0;
        e.seen = 1'b0;
        e.z    = (d == '0);
        if (e.z) begin
            e.d = '0;
            e.s = W'(N - 1);
        end else begin
            c = 0;
            if (dir == 1'b0) begin
                while (d[N-1-c] == 1'b0) c++;
                e.d = d << c;
            end else begin
                while (d[c] == 1'b0) c++;
                e.d = d >> c;
            end
            e.s = W'(c);
        end
        return e;
    endfunction

    initial forever @(posedge clk) cyc++;

    initial begin : monitor
        bit   pv;
        bit   pr;
        exp_t e;
        res_t r;
        pv = 1'b0;
        pr = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                pv = 1'b0;
            end else begin
                if (pv && !pr && !io.out_valid) chk("valid_drop", 0, 1);
                if (io.out_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("spurious_valid", 1, 0);
                    end else begin
                        if (!exp_q[0].seen) begin
                            chk("latency", cyc - exp_q[0].acc, 4);
                            exp_q[0].seen = 1'b1;
                        end
                        chk("mdl_data", io.out_data, exp_q[0].d);
                        chk("mdl_shift", io.out_shift, exp_q[0].s);
                        chk("mdl_zero", io.out_zero, exp_q[0].z);
                        if (io.out_ready) begin
                            r.d   = io.out_data;
                            r.s   = io.out_shift;
                            r.z   = io.out_zero;
                            r.cyc = cyc;
                            res_q.push_back(r);
                            void'(exp_q.pop_front());
                        end
                    end
                end
                if (io.in_valid && io.in_ready) begin
                    e     = model(io.in_data, io.in_dir);
                    e.acc = cyc;
                    exp_q.push_back(e);
                end
                pv = io.out_valid;
                pr = io.out_ready;
            end
        end
    end

    task automatic send(input logic [N-1:0] d, input logic dir,
                        input logic [N-1:0] ed, input logic [W-1:0] es,
                        input logic ez, input int hold);
        int   n;
        exp_t m;
        m = model(d, dir);
        chk("model_data", m.d, ed);
        chk("model_shift", m.s, es);
        @(posedge clk);
        #1;
        io.in_valid = 1'b1;
        io.in_data  = d;
        io.in_dir   = dir;
        n = 0;
        @(negedge clk);
        while (!io.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!io.in_ready) chk("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        io.in_valid = 1'b0;
        io.in_data  = ~d;
        io.in_dir   = ~dir;
        n = 0;
        while (!io.out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!io.out_valid) begin
            chk("result_timeout", 0, 1);
        end else begin
            chk("out_data", io.out_data, ed);
            chk("out_shift", io.out_shift, es);
            chk("out_zero", io.out_zero, ez);
            repeat (hold) begin
                @(negedge clk);
                chk("bp_valid", io.out_valid, 1);
                chk("bp_in_ready", io.in_ready, 0);
                chk("bp_data", io.out_data, ed);
                chk("bp_shift", io.out_shift, es);
            end
        end
        @(posedge clk);
        #1;
        io.out_ready = 1'b1;
        @(posedge clk);
        #1;
        io.out_ready = 1'b0;
        chk("idle_valid", io.out_valid, 0);
        chk("idle_in_ready", io.in_ready, 1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        rst          = 1'b1;
        io.in_valid  = 1'b0;
        io.in_data   = '0;
        io.in_dir    = 1'b0;
        io.out_ready = 1'b0;
        #1;
        chk("rst_in_ready", io.in_ready, 1);
        chk("rst_out_valid", io.out_valid, 0);
        chk("rst_out_data", io.out_data, 0);
        chk("rst_out_shift", io.out_shift, 0);
        chk("rst_out_zero", io.out_zero, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        send(8'h10, 1'b0, 8'h80, 3'd3, 1'b0, 0);
        send(8'h01, 1'b0, 8'h80, 3'd7, 1'b0, 0);
        send(8'hC3, 1'b0, 8'hC3, 3'd0, 1'b0, 0);
        send(8'h28, 1'b1, 8'h05, 3'd3, 1'b0, 0);
        send(8'h00, 1'b1, 8'h00, 3'd7, 1'b1, 0);
        send(8'h00, 1'b0, 8'h00, 3'd7, 1'b1, 0);
        send(8'h80, 1'b1, 8'h01, 3'd7, 1'b0, 0);
        send(8'hFF, 1'b1, 8'hFF, 3'd0, 1'b0, 0);
        send(8'h08, 1'b1, 8'h01, 3'd3, 1'b0, 5);

        // Reset in the second SHIFT cycle discards the word in flight.
        @(posedge clk);
        #1;
        io.in_valid = 1'b1;
        io.in_data  = 8'h55;
        io.in_dir   = 1'b0;
        @(posedge clk);
        #1;
        io.in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", io.out_valid, 0);
        chk("mid_rst_in_ready", io.in_ready, 1);
        chk("mid_rst_shift", io.out_shift, 0);
        chk("mid_rst_data", io.out_data, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        send(8'h04, 1'b0, 8'h80, 3'd5, 1'b0, 0);

`ifdef NORM_BACK2BACK_EN
        begin : b2b
            logic [N-1:0] wd[3];
            logic [N-1:0] ed[3];
            logic [W-1:0] es[3];
            logic         ez[3];
            int           n;
            wd = '{8'h40, 8'h02, 8'h00};
            ed = '{8'h80, 8'h80, 8'h00};
            es = '{3'd1, 3'd6, 3'd7};
            ez = '{1'b0, 1'b0, 1'b1};
            res_q.delete();
            @(posedge clk);
            #1;
            io.out_ready = 1'b1;
            for (int i = 0; i < 3; i++) begin
                io.in_valid = 1'b1;
                io.in_data  = wd[i];
                io.in_dir   = 1'b0;
                n = 0;
                @(negedge clk);
                while (!io.in_ready && n < 20) begin
                    @(negedge clk);
                    n++;
                end
                if (!io.in_ready) chk("b2b_accept_timeout", 0, 1);
                @(posedge clk);
                #1;
            end
            io.in_valid = 1'b0;
            n = 0;
            while (res_q.size() < 3 && n < 40) begin
                @(negedge clk);
                n++;
            end
            chk("b2b_count", res_q.size(), 3);
            for (int i = 0; i < 3 && i < res_q.size(); i++) begin
                chk("b2b_data", res_q[i].d, ed[i]);
                chk("b2b_shift", res_q[i].s, es[i]);
                chk("b2b_zero", res_q[i].z, ez[i]);
                if (i > 0) chk("b2b_gap", res_q[i].cyc - res_q[i-1].cyc, 4);
            end
            io.out_ready = 1'b0;
        end
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("end_queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
